// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The slave modport is the loader's view; master is the source/memory side.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a little-endian byte stream into
// 32-bit words, writes them to consecutive word addresses and stalls the core.
module imem_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [15:0]   i_len_words,
  imem_loader_if.slave  bus,
  output logic          o_cpu_hold,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t       r_state, w_state_nx;
  logic [1:0]   r_byte_cnt;
  logic [23:0]  r_word;
  logic [15:0]  r_word_idx;
  logic [15:0]  r_len;

  logic         r_in_ready, r_wr_en, r_cpu_hold, r_busy, r_done, r_err;
  logic [63:0]  r_wr_addr;
  logic [31:0]  r_wr_data;

  logic         w_in_ready, w_wr_en, w_cpu_hold, w_busy, w_done, w_err;
  logic [63:0]  w_wr_addr;
  logic [31:0]  w_wr_data;
  logic         w_accept, w_len_ok;

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_len_ok = (i_len_words != 16'd0) && ({1'b0, i_len_words} <= MAX_W);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR:
        if (i_start) w_state_nx = w_len_ok ? S_RECV : S_ERR;
      S_RECV:
        if (w_accept && r_byte_cnt == 2'd3) w_state_nx = S_WRITE;
      S_WRITE:
        w_state_nx = (r_word_idx + 16'd1 == r_len) ? S_DONE : S_RECV;
      default:
        w_state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered, so each one
  // changes on the same edge as the state it belongs to.
  always_comb begin
    w_in_ready = (w_state_nx == S_RECV);
    w_wr_en    = (w_state_nx == S_WRITE);
    w_busy     = (w_state_nx == S_RECV) || (w_state_nx == S_WRITE);
    w_done     = (w_state_nx == S_DONE);
    w_err      = (w_state_nx == S_ERR);
    w_cpu_hold = (w_state_nx != S_DONE);
    w_wr_addr  = r_wr_addr;
    w_wr_data  = r_wr_data;
    if (r_state == S_RECV && w_state_nx == S_WRITE) begin
      w_wr_addr = BASE_ADDR + {46'd0, r_word_idx, 2'b00};
      w_wr_data = {bus.in_data, r_word};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_in_ready <= w_in_ready;
      r_wr_en    <= w_wr_en;
      r_wr_addr  <= w_wr_addr;
      r_wr_data  <= w_wr_data;
      r_cpu_hold <= w_cpu_hold;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  // Byte 3 is never stored: it goes straight into the write word above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_word     <= '0;
      r_word_idx <= '0;
      r_len      <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR:
          if (i_start && w_len_ok) begin
            r_len      <= i_len_words;
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
          end
        S_RECV:
          if (w_accept) begin
            case (r_byte_cnt)
              2'd0:    r_word[7:0]   <= bus.in_data;
              2'd1:    r_word[15:8]  <= bus.in_data;
              2'd2:    r_word[23:16] <= bus.in_data;
              default: ;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        S_WRITE:
          r_word_idx <= r_word_idx + 16'd1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected writes built from
// the byte stream, table-driven length vectors and directed corner sequences.
module tb_imem_loader;

  localparam logic [63:0] BASE      = 64'h0;
  localparam int          MAX_WORDS = 256;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len_words;
  logic        cpu_hold, busy, done, err;

  imem_loader_if bus ();

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .i_len_words(len_words),
    .bus        (bus),
    .o_cpu_hold (cpu_hold),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] len;
    bit          exp_err;
    int          pct;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_wr_cyc = 0;
  logic [31:0] last_wr_data = '0;
  logic        prev_wr_en = 1'b0;
  logic [7:0]  bytes_q[$];
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          bidx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write monitor: every strobe must match the next expected (addr, word).
  always @(negedge clk) begin
    if (bus.wr_en) begin
      wr_cnt++;
      last_wr_cyc  = cyc;
      last_wr_data = bus.wr_data;
      check("in_ready_low_in_write", bus.in_ready, 0);
      check("wr_en_single_cycle", prev_wr_en, 0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, mon_e.addr);
        check("wr_data", bus.wr_data, mon_e.data);
      end
    end
    prev_wr_en = bus.wr_en;
  end

  task automatic prep_random(input int n);
    bytes_q.delete();
    for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
  endtask

  // Reference model: word i is bytes 4i..4i+3 little-endian, at BASE + 4i.
  task automatic begin_load(input logic [15:0] len);
    wr_t w;
    wr_cnt = 0;
    if (len != 0 && int'(len) <= MAX_WORDS) begin
      for (int i = 0; i < int'(len); i++) begin
        w.addr = BASE + 64'(4 * i);
        w.data = {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]};
        exp_q.push_back(w);
      end
    end
    @(negedge clk);
    start     = 1'b1;
    len_words = len;
    @(negedge clk);
    start     = 1'b0;
    len_words = 16'($urandom);
    bidx      = 0;
  endtask

  task automatic feed(input int n, input int pct);
    int  guard = 0;
    int  bound = 50 * n + 100;
    bit  v;
    logic rdy;
    while (n > 0 && guard < bound) begin
      v            = ($urandom_range(99) < pct);
      bus.in_valid = v;
      bus.in_data  = bytes_q[bidx];
      rdy          = bus.in_ready;
      @(posedge clk);
      if (v && rdy) begin
        bidx++;
        n--;
      end
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    if (n > 0) check("feed_timeout_bytes_left", 64'(n), 0);
  endtask

  task automatic wait_done(input int bound);
    int t = 0;
    while (!done && t < bound) begin
      @(negedge clk);
      t++;
    end
    check("done", done, 1);
    check("cpu_hold_after_done", cpu_hold, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_wr_en"}, bus.wr_en, 0);
    check({tag, "_wr_addr"}, bus.wr_addr, 0);
    check({tag, "_wr_data"}, bus.wr_data, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];
  int   t0;

  initial begin
    vecs[0] = '{16'd0,     1'b1, 100};
    vecs[1] = '{16'd257,   1'b1, 100};
    vecs[2] = '{16'hFFFF,  1'b1, 100};
    vecs[3] = '{16'd1,     1'b0, 60};
    vecs[4] = '{16'd2,     1'b0, 30};
    vecs[5] = '{16'd5,     1'b0, 80};
    vecs[6] = '{16'd256,   1'b0, 50};

    rst_n = 1'b0; start = 1'b0; len_words = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    #12;
    check_reset_values("reset");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // L=1 known instruction word
    bytes_q = '{8'h13, 8'h00, 8'h50, 8'h00};
    begin_load(16'd1);
    check("l1_in_ready_after_start", bus.in_ready, 1);
    feed(4, 100);
    begin
      int t = 0;
      while (!bus.wr_en && t < 20) begin @(negedge clk); t++; end
    end
    @(negedge clk);
    check("l1_done_next_cycle", done, 1);
    check("l1_cpu_hold_next_cycle", cpu_hold, 0);
    check("l1_word", last_wr_data, 32'h00500013);
    check("l1_write_count", wr_cnt, 1);

    // L=3 continuous: 15 cycles from first RECV cycle to last write
    bytes_q.delete();
    for (int i = 1; i <= 12; i++) bytes_q.push_back(8'(i));
    begin_load(16'd3);
    t0 = cyc;
    check("l3_in_ready_first_recv", bus.in_ready, 1);
    feed(12, 100);
    wait_done(100);
    check("l3_load_cycles", 64'(last_wr_cyc - t0 + 1), 15);
    check("l3_write_count", wr_cnt, 3);
    check("l3_scoreboard_empty", exp_q.size(), 0);

    // L=3 with bursty valid: same writes
    begin_load(16'd3);
    feed(12, 50);
    wait_done(400);
    check("l3r_write_count", wr_cnt, 3);
    check("l3r_scoreboard_empty", exp_q.size(), 0);

    // Illegal lengths, then a legal load clears err
    begin_load(16'd0);
    check("len0_err", err, 1);
    check("len0_cpu_hold", cpu_hold, 1);
    check("len0_done_cleared", done, 0);
    check("len0_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("len0_err_sticky", err, 1);
    check("len0_no_write", wr_cnt, 0);
    begin_load(16'(MAX_WORDS + 1));
    check("lenmax1_err", err, 1);
    check("lenmax1_cpu_hold", cpu_hold, 1);
    prep_random(4);
    begin_load(16'd1);
    check("legal_after_err_err", err, 0);
    check("legal_after_err_busy", busy, 1);
    feed(4, 70);
    wait_done(200);
    check("legal_after_err_writes", wr_cnt, 1);

    // Table of lengths with random data and valid density
    foreach (vecs[k]) begin
      if (!vecs[k].exp_err) prep_random(4 * int'(vecs[k].len));
      begin_load(vecs[k].len);
      check("tbl_err", err, 64'(vecs[k].exp_err));
      check("tbl_busy", busy, 64'(!vecs[k].exp_err));
      if (!vecs[k].exp_err) begin
        feed(4 * int'(vecs[k].len), vecs[k].pct);
        wait_done(30 * int'(vecs[k].len) + 50);
        check("tbl_write_count", 64'(wr_cnt), 64'(vecs[k].len));
        check("tbl_scoreboard_empty", exp_q.size(), 0);
      end else begin
        repeat (3) @(negedge clk);
        check("tbl_no_write", wr_cnt, 0);
        check("tbl_cpu_hold", cpu_hold, 1);
      end
    end

    // start during RECV with another length is ignored
    prep_random(8);
    begin_load(16'd2);
    feed(3, 100);
    start = 1'b1; len_words = 16'd5;
    @(negedge clk);
    start = 1'b0;
    check("restart_ignored_busy", busy, 1);
    feed(5, 100);
    wait_done(100);
    check("restart_ignored_writes", wr_cnt, 2);
    check("restart_ignored_scoreboard", exp_q.size(), 0);

    // Async reset after byte 2 of word 1, then a fresh load
    prep_random(8);
    begin_load(16'd2);
    feed(7, 100);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("midreset_writes", wr_cnt, 1);
    rst_n = 1'b1;
    @(negedge clk);
    prep_random(8);
    begin_load(16'd2);
    feed(8, 75);
    wait_done(200);
    check("post_reset_writes", wr_cnt, 2);
    check("post_reset_scoreboard", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
